// File: rtl/serializer_pkg.sv
// Shared types and constants for the PISO serializer.
// Optional macro SERIALIZER_PARITY_EN appends an even-parity bit to each frame.
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

`ifdef SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of serial bit cycles per frame for a given data width.
    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable right-shift register with zero fill; exposes bit 0.
// Holds the not-yet-transmitted data bits of the current frame.
module piso_shift_reg
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit0_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    // Storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit0_o = sr_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: valid/ready word in, LSB-first bit stream out.
// Build option SERIALIZER_PARITY_EN appends an even-parity bit after the MSB.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sout_q;
    logic             sout_d;
    logic             fs_q;
    logic             fs_d;

    logic             last_bit;
    logic             accept;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_bit0;
    logic [WIDTH-1:0] sr_load_val;

`ifdef SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH - 1);
    logic par_q;
    logic par_d;
`endif

    // Bit 0 goes straight to sout at load, so the register keeps the rest.
    assign sr_load_val = {1'b0, din[WIDTH-1:1]};

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (sr_load_val),
        .bit0_o  (sr_bit0)
    );

    assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
    assign din_ready = (state_q == ST_IDLE) || last_bit;
    assign accept    = din_valid && din_ready;

    // Next-state, counter and next output bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sout_d   = 1'b0;
        fs_d     = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d    = par_q;
`endif
        if (accept) begin
            sr_load = 1'b1;
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sout_d  = din[0];
            fs_d    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            par_d   = ^din;
`endif
        end else if (state_q == ST_SHIFT) begin
            if (last_bit) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                sr_shift = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                sout_d   = sr_bit0;
`ifdef SERIALIZER_PARITY_EN
                if (cnt_q == PAR_IDX) begin
                    sout_d = par_q;
                end
`endif
            end
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            fs_q    <= fs_d;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    // Parity of the word being sent, captured at load.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign sout        = sout_q;
    assign frame_start = fs_q;
    assign sout_valid  = (state_q == ST_SHIFT);
    assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (default build; parity steps
// are included when SERIALIZER_PARITY_EN is defined).
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout;
    logic       sout_valid;
    logic       frame_start;
    logic       busy;

    int checks = 0;
    int errors = 0;

    piso_serializer #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(sout_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sout"}, 32'(sout), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_ready"}, 32'(din_ready), 32'd1);
    endtask

    task automatic chk_bit(input string tag, input logic b, input logic fs, input logic rdy);
        chk({tag, "_sout"}, 32'(sout), 32'(b));
        chk({tag, "_valid"}, 32'(sout_valid), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_fs"}, 32'(frame_start), 32'(fs));
        chk({tag, "_ready"}, 32'(din_ready), 32'(rdy));
    endtask

    initial begin
        logic [15:0] pat;
        logic [7:0]  w;

        // Reset held with a valid word presented: nothing may start.
        rst       = 1'b1;
        din       = 8'hA5;
        din_valid = 1'b1;
        tick();
        chk("rst1_valid", 32'(sout_valid), 32'd0);
        chk("rst1_busy", 32'(busy), 32'd0);
        tick();
        chk("rst2_valid", 32'(sout_valid), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_sout", 32'(sout), 32'd0);
        chk("rst2_fs", 32'(frame_start), 32'd0);
        din_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("post_rst_ready", 32'(din_ready), 32'd1);
        tick();
        chk_idle("post_rst");

        // Single word A5 -> 1,0,1,0,0,1,0,1.
        w         = 8'hA5;
        din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        din       = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("a5_b%0d", i), w[i], i == 0, i == 7);
            tick();
        end
        chk_idle("a5_end");

        // Back-to-back 0F then F0 with no gap.
        pat       = 16'hF00F;
        din       = 8'h0F;
        din_valid = 1'b1;
        tick();
        din       = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            chk_bit($sformatf("b2b_b%0d", i), pat[i], i == 0 || i == 8,
                    i == 7 || i == 15);
            if (i == 8) din_valid = 1'b0;
            tick();
        end
        chk_idle("b2b_end");

        // Reset after three bits of FF, then a clean 01.
        din       = 8'hFF;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_bit($sformatf("ff_b%0d", i), 1'b1, i == 0, 1'b0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst");
        w         = 8'h01;
        din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("x01_b%0d", i), w[i], i == 0, i == 7);
            tick();
        end
        chk_idle("x01_end");

        // Stall: no valid, din wiggles, nothing happens.
        for (int i = 0; i < 5; i++) begin
            din = 8'($urandom);
            tick();
            chk(($sformatf("stall%0d_valid", i)), 32'(sout_valid), 32'd0);
            chk(($sformatf("stall%0d_ready", i)), 32'(din_ready), 32'd1);
            chk(($sformatf("stall%0d_busy", i)), 32'(busy), 32'd0);
        end

`ifdef SERIALIZER_PARITY_EN
        // 07: data 1,1,1,0,0,0,0,0 then parity 1.
        pat       = 16'h0107;
        din       = 8'h07;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_bit($sformatf("p07_b%0d", i), pat[i], i == 0, i == 8);
            tick();
        end
        chk_idle("p07_end");
        // 03: parity 0.
        pat       = 16'h0003;
        din       = 8'h03;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_bit($sformatf("p03_b%0d", i), pat[i], i == 0, i == 8);
            tick();
        end
        chk_idle("p03_end");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
